// File: rtl/bullet_updater.sv
// Bullet updater: once per frame, sweeps every slot of the bullet RAM.
// Each slot is read, then written back on the next cycle. Live bullets move
// and age, expired or off-screen bullets are cleared, and one pending spawn
// can be placed into the first free slot of the sweep.
//
// Spawn handshake (valid/ready): a spawn transfers on a rising edge where
// spawn_valid && spawn_ready. spawn_ready is high exactly when the holding
// register is empty. A held spawn is never dropped: it waits until a sweep
// finds a free slot. spawn_data is sampled only on a transfer edge.
module bullet_updater #(
    parameter int NUM_BULLETS   = 64,
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_WIDTH    = 32,
    parameter int SPEED         = 2,
    parameter int X_MAX         = 639,
    parameter int Y_MAX         = 479
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame_tick,
    input  logic                     spawn_valid,
    input  logic [DATA_WIDTH-1:0]    spawn_data,
    output logic                     spawn_ready,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic                     ram_readEn,
    output logic                     ram_wEn,
    output logic [DATA_WIDTH-1:0]    ram_dataIn,
    input  logic [DATA_WIDTH-1:0]    ram_dataOut,
    output logic                     busy,
    output logic                     sweep_done,
    output logic [ADDRESS_WIDTH:0]   active_count,
    output logic                     overrun,
    output logic [1:0]               dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READ   = 2'd1,
        S_UPDATE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [10:0] L_SPEED = 11'(SPEED);
    localparam logic [10:0] L_X_MAX = 11'(X_MAX);
    localparam logic [10:0] L_Y_MAX = 11'(Y_MAX);
    localparam logic [ADDRESS_WIDTH-1:0] L_LAST = ADDRESS_WIDTH'(NUM_BULLETS - 1);

    state_t                   r_state;
    logic [ADDRESS_WIDTH-1:0] r_index;
    logic                     r_read_en;
    logic                     r_w_en;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_held;
    logic [DATA_WIDTH-1:0]    r_spawn;
    logic                     r_spawn_used;
    logic [ADDRESS_WIDTH:0]   r_live;
    logic [ADDRESS_WIDTH:0]   r_active_count;
    logic                     r_overrun;

    logic [10:0]              w_x;
    logic [10:0]              w_y;
    logic [10:0]              w_nx;
    logic [10:0]              w_ny;
    logic                     w_kill;
    logic                     w_take_spawn;
    logic [DATA_WIDTH-1:0]    w_next;

    // Compute the record to write back for the slot currently on ram_dataOut.
    always_comb begin
        w_x          = {1'b0, ram_dataOut[28:19]};
        w_y          = {2'b0, ram_dataOut[18:10]};
        w_nx         = w_x;
        w_ny         = w_y;
        w_kill       = 1'b0;
        w_take_spawn = 1'b0;
        w_next       = '0;
        if (ram_dataOut[31]) begin
            if (ram_dataOut[9:0] == 10'd0) begin
                w_kill = 1'b1;
            end else begin
                case (ram_dataOut[30:29])
                    2'd0: begin
                        if (w_y < L_SPEED) w_kill = 1'b1;
                        else               w_ny   = w_y - L_SPEED;
                    end
                    2'd1: begin
                        w_nx = w_x + L_SPEED;
                        if (w_nx > L_X_MAX) w_kill = 1'b1;
                    end
                    2'd2: begin
                        w_ny = w_y + L_SPEED;
                        if (w_ny > L_Y_MAX) w_kill = 1'b1;
                    end
                    default: begin
                        if (w_x < L_SPEED) w_kill = 1'b1;
                        else               w_nx   = w_x - L_SPEED;
                    end
                endcase
            end
            if (!w_kill) begin
                w_next[31]    = 1'b1;
                w_next[30:29] = ram_dataOut[30:29];
                w_next[28:19] = w_nx[9:0];
                w_next[18:10] = w_ny[8:0];
                w_next[9:0]   = ram_dataOut[9:0] - 10'd1;
            end
        end else if (r_held && !r_spawn_used) begin
            // Free slot with a spawn waiting: place it, placed bullets do not move yet.
            w_take_spawn = 1'b1;
            w_next       = r_spawn;
            w_next[31]   = 1'b1;
        end else begin
            w_next = ram_dataOut;
        end
    end

    // Sweep sequencer, spawn holding register, live counter and overrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_index        <= '0;
            r_read_en      <= 1'b0;
            r_w_en         <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_held         <= 1'b0;
            r_spawn        <= '0;
            r_spawn_used   <= 1'b0;
            r_live         <= '0;
            r_active_count <= '0;
            r_overrun      <= 1'b0;
        end else begin
            // Load only when empty; a consume this cycle frees the slot for next cycle.
            if (spawn_valid && !r_held) begin
                r_held  <= 1'b1;
                r_spawn <= spawn_data;
            end
            if (frame_tick && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (frame_tick) begin
                        r_state      <= S_READ;
                        r_index      <= '0;
                        r_read_en    <= 1'b1;
                        r_busy       <= 1'b1;
                        r_live       <= '0;
                        r_spawn_used <= 1'b0;
                    end
                end
                S_READ: begin
                    r_state   <= S_UPDATE;
                    r_read_en <= 1'b0;
                    r_w_en    <= 1'b1;
                end
                S_UPDATE: begin
                    r_w_en <= 1'b0;
                    if (w_next[31]) begin
                        r_live <= r_live + (ADDRESS_WIDTH+1)'(1);
                    end
                    if (w_take_spawn) begin
                        r_held       <= 1'b0;
                        r_spawn_used <= 1'b1;
                    end
                    if (r_index == L_LAST) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state   <= S_READ;
                        r_index   <= r_index + ADDRESS_WIDTH'(1);
                        r_read_en <= 1'b1;
                    end
                end
                default: begin
                    r_state        <= S_IDLE;
                    r_done         <= 1'b0;
                    r_busy         <= 1'b0;
                    r_active_count <= r_live;
                end
            endcase
        end
    end

    assign spawn_ready  = !r_held;
    assign ram_readEn   = r_read_en;
    assign ram_wEn      = r_w_en;
    assign ram_addr     = (r_read_en || r_w_en) ? r_index : '0;
    assign ram_dataIn   = r_w_en ? w_next : '0;
    assign busy         = r_busy;
    assign sweep_done   = r_done;
    assign active_count = r_active_count;
    assign overrun      = r_overrun;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_bullet_updater.sv
// Bench for bullet_updater: a RAM model answers the DUT, and a slot-level
// reference model predicts every write-back, the final RAM image, the live
// count and the spawn handshake.
module tb_bullet_updater;

    localparam int N     = 64;
    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int SPEED = 2;
    localparam int X_MAX = 639;
    localparam int Y_MAX = 479;

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_tick;
    logic          spawn_valid;
    logic [DW-1:0] spawn_data;
    logic          spawn_ready;
    logic [AW-1:0] ram_addr;
    logic          ram_readEn;
    logic          ram_wEn;
    logic [DW-1:0] ram_dataIn;
    logic [DW-1:0] ram_dataOut;
    logic          busy;
    logic          sweep_done;
    logic [AW:0]   active_count;
    logic          overrun;
    logic [1:0]    dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state
    logic [DW-1:0] ref_mem[N];
    logic [DW-1:0] exp_mem[N];
    logic [DW-1:0] exp_q[$];
    bit            m_held = 1'b0;
    logic [DW-1:0] m_spawn;
    bit            m_overrun = 1'b0;

    // RAM model
    logic [DW-1:0] mem[N];
    logic [DW-1:0] rd_q;

    always #5 clk = ~clk;

    bullet_updater #(
        .NUM_BULLETS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
        .SPEED(SPEED), .X_MAX(X_MAX), .Y_MAX(Y_MAX)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .spawn_valid(spawn_valid), .spawn_data(spawn_data), .spawn_ready(spawn_ready),
        .ram_addr(ram_addr), .ram_readEn(ram_readEn), .ram_wEn(ram_wEn),
        .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut),
        .busy(busy), .sweep_done(sweep_done), .active_count(active_count),
        .overrun(overrun), .dbg_state(dbg_state)
    );

    // Synchronous RAM: read data one cycle after the read enable
    always @(posedge clk) begin
        if (ram_wEn) mem[ram_addr] <= ram_dataIn;
        if (ram_readEn) rd_q <= mem[ram_addr];
    end
    assign ram_dataOut = rd_q;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] make_rec(input int a, input int d, input int x, input int y, input int l);
        logic [31:0] r;
        r[31]    = a[0];
        r[30:29] = d[1:0];
        r[28:19] = x[9:0];
        r[18:10] = y[8:0];
        r[9:0]   = l[9:0];
        return r;
    endfunction

    // One frame of motion for a single slot, in plain integer arithmetic
    function automatic logic [31:0] model_next(input logic [31:0] r);
        int x, y, life, dir;
        x = int'(r[28:19]); y = int'(r[18:10]); life = int'(r[9:0]); dir = int'(r[30:29]);
        if (!r[31]) return r;
        if (life == 0) return 32'd0;
        case (dir)
            0: begin y = y - SPEED; if (y < 0) return 32'd0; end
            1: begin x = x + SPEED; if (x > X_MAX) return 32'd0; end
            2: begin y = y + SPEED; if (y > Y_MAX) return 32'd0; end
            default: begin x = x - SPEED; if (x < 0) return 32'd0; end
        endcase
        return make_rec(1, dir, x, y, life - 1);
    endfunction

    function automatic int pick_coord(input int maxv);
        case ($urandom_range(0, 2))
            0: return int'($urandom_range(0, 3));
            1: return int'($urandom_range(maxv - 3, maxv));
            default: return int'($urandom_range(0, maxv));
        endcase
    endfunction

    function automatic logic [31:0] rand_rec();
        logic [31:0] r;
        if ($urandom_range(0, 3) == 0) begin
            r = $urandom();
            r[31] = 1'b0;
            return r;
        end
        return make_rec(1, int'($urandom_range(0, 3)), pick_coord(X_MAX), pick_coord(Y_MAX),
                        ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 1023)));
    endfunction

    task automatic set_slot(input int s, input logic [31:0] v);
        mem[s] <= v;
        ref_mem[s] = v;
    endtask

    task automatic cmp_mem();
        for (int i = 0; i < N; i++) chk("mem", 64'(mem[i]), 64'(ref_mem[i]));
    endtask

    task automatic load_spawn(input logic [31:0] d);
        chk("ready_pre", 64'(spawn_ready), 64'(!m_held));
        spawn_valid = 1'b1;
        spawn_data  = d;
        @(negedge clk);
        spawn_valid = 1'b0;
        if (!m_held) begin m_held = 1'b1; m_spawn = d; end
        chk("ready_post", 64'(spawn_ready), 64'(!m_held));
    endtask

    // One sweep: tick_at re-ticks mid-sweep, rst_at resets mid-sweep (-1: none),
    // offer keeps spawn_valid high with offer_data for the whole sweep.
    task automatic run_sweep(input int tick_at, input int rst_at, input bit offer, input logic [31:0] offer_data);
        int  cc;
        int  live;
        bit  used;
        bit  start_held;
        bit  exp_rdy;
        bit  any_w;
        logic [31:0] n;
        start_held = m_held;
        if (offer && !m_held) begin m_held = 1'b1; m_spawn = offer_data; end
        used = 1'b0; cc = -1; live = 0;
        exp_q.delete();
        for (int s = 0; s < N; s++) begin
            if (ref_mem[s][31]) n = model_next(ref_mem[s]);
            else if (m_held && !used) begin
                n = m_spawn | 32'h8000_0000;
                used = 1'b1; m_held = 1'b0; cc = 2 * s + 2;
            end else n = ref_mem[s];
            if (n[31]) live++;
            exp_q.push_back(n);
            exp_mem[s] = n;
        end
        if (offer && !m_held) begin m_held = 1'b1; m_spawn = offer_data; end

        spawn_valid = offer;
        spawn_data  = offer_data;
        frame_tick  = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 2 * N + 1; c++) begin
            frame_tick = (c == tick_at);
            if (c <= 2 * N) begin
                chk("rd_en", 64'(ram_readEn), 64'(c % 2));
                chk("w_en", 64'(ram_wEn), 64'((c + 1) % 2));
                chk("addr", 64'(ram_addr), 64'((c - 1) / 2));
                if (c % 2 == 0) chk("wdata", 64'(ram_dataIn), 64'(exp_q.pop_front()));
                chk("busy", 64'(busy), 64'd1);
                chk("done", 64'(sweep_done), 64'd0);
            end else begin
                chk("done", 64'(sweep_done), 64'd1);
                chk("busy_done", 64'(busy), 64'd1);
                chk("rw_done", 64'({ram_readEn, ram_wEn}), 64'd0);
            end
            if (offer) exp_rdy = (c == cc + 1);
            else exp_rdy = !(start_held && (cc < 0 || c <= cc));
            chk("ready", 64'(spawn_ready), 64'(exp_rdy));
            if (tick_at > 0 && c == tick_at + 1) chk("overrun", 64'(overrun), 64'd1);
            if (c == rst_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                frame_tick = 1'b0;
                spawn_valid = 1'b0;
                m_held = 1'b0; m_overrun = 1'b0;
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_rw", 64'({ram_readEn, ram_wEn}), 64'd0);
                chk("rst_overrun", 64'(overrun), 64'd0);
                chk("rst_ready", 64'(spawn_ready), 64'd1);
                chk("rst_count", 64'(active_count), 64'd0);
                any_w = 1'b0;
                repeat (20) begin @(negedge clk); any_w |= ram_wEn; end
                chk("no_wr_after_rst", 64'(any_w), 64'd0);
                for (int s = 0; s < N; s++) if (2 * s + 2 <= rst_at) ref_mem[s] = exp_mem[s];
                exp_q.delete();
                cmp_mem();
                return;
            end
            @(negedge clk);
        end
        frame_tick = 1'b0;
        spawn_valid = 1'b0;
        if (tick_at > 0) m_overrun = 1'b1;
        chk("busy_after", 64'(busy), 64'd0);
        chk("done_after", 64'(sweep_done), 64'd0);
        chk("active_count", 64'(active_count), 64'(live));
        chk("ready_after", 64'(spawn_ready), 64'(!m_held));
        chk("overrun_after", 64'(overrun), 64'(m_overrun));
        for (int s = 0; s < N; s++) ref_mem[s] = exp_mem[s];
        cmp_mem();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; frame_tick = 1'b0; spawn_valid = 1'b0; spawn_data = '0;
        for (int i = 0; i < N; i++) set_slot(i, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(sweep_done), 64'd0);
        chk("rst_rd", 64'(ram_readEn), 64'd0);
        chk("rst_wr", 64'(ram_wEn), 64'd0);
        chk("rst_addr", 64'(ram_addr), 64'd0);
        chk("rst_wdata", 64'(ram_dataIn), 64'd0);
        chk("rst_count", 64'(active_count), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_ready", 64'(spawn_ready), 64'd1);

        // Single bullet moving right
        set_slot(5, make_rec(1, 1, 100, 50, 10));
        @(negedge clk);
        run_sweep(-1, -1, 1'b0, 32'd0);
        chk("single_slot5", 64'(mem[5]), 64'(make_rec(1, 1, 102, 50, 9)));
        chk("single_count", 64'(active_count), 64'd1);

        // Edge exits
        for (int i = 0; i < N; i++) set_slot(i, 32'd0);
        set_slot(0, make_rec(1, 3, 1, 10, 5));
        set_slot(1, make_rec(1, 2, 10, 478, 5));
        @(negedge clk);
        run_sweep(-1, -1, 1'b0, 32'd0);
        chk("exit_slot0", 64'(mem[0]), 64'd0);
        chk("exit_slot1", 64'(mem[1]), 64'd0);
        chk("exit_count", 64'(active_count), 64'd0);

        // Spawn into first free slot
        for (int i = 0; i < N; i++) set_slot(i, 32'd0);
        for (int i = 0; i < 3; i++) set_slot(i, make_rec(1, 1, 10, 10, 5));
        set_slot(4, 32'h0000_1234);
        @(negedge clk);
        load_spawn(32'h1234_5678);
        run_sweep(-1, -1, 1'b0, 32'd0);
        chk("spawn_slot3", 64'(mem[3]), 64'h9234_5678);
        chk("spawn_slot4", 64'(mem[4]), 64'h0000_1234);
        chk("spawn_ready", 64'(spawn_ready), 64'd1);

        // Full table keeps the spawn held
        for (int i = 0; i < N; i++) set_slot(i, make_rec(1, 2, 5 * i, 100, 100));
        @(negedge clk);
        load_spawn(32'h0000_0abc);
        run_sweep(-1, -1, 1'b0, 32'd0);
        chk("full_count", 64'(active_count), 64'd64);
        chk("full_ready", 64'(spawn_ready), 64'd0);

        // Overrun, then overrun plus mid-sweep reset
        run_sweep(40, -1, 1'b0, 32'd0);
        run_sweep(40, 60, 1'b0, 32'd0);

        // Random tables, spawns and concurrent offers
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < N; i++) set_slot(i, rand_rec());
            @(negedge clk);
            if ($urandom_range(0, 1) == 1) load_spawn($urandom());
            run_sweep(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 120)) : -1, -1,
                      $urandom_range(0, 2) == 0, $urandom());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bullet_updater.md
BULLET_UPDATER -- requirements
Module: bullet_updater

Interface
REQ-001 Parameter NUM_BULLETS, default 64, number of bullet slots swept per frame.
REQ-002 Parameter ADDRESS_WIDTH, default 6, slot address width.
REQ-003 Parameter DATA_WIDTH, default 32, bullet record width.
REQ-004 Parameter SPEED, default 2, pixels moved per frame.
REQ-005 Parameter X_MAX, default 639, largest legal x.
REQ-006 Parameter Y_MAX, default 479, largest legal y.
REQ-007 One clock; reset is synchronous and active-high.
REQ-008 Port clk  in  1  system clock; all state updates on its rising edge.
REQ-009 Port reset  in  1  synchronous, active-high reset.
REQ-010 Port frame_tick  in  1  single-cycle pulse that starts one sweep.
REQ-011 Port spawn_valid  in  1  new-bullet request.
REQ-012 Port spawn_data  in  DATA_WIDTH  new-bullet record.
REQ-013 Port spawn_ready  out  1  high when the spawn holding register is empty.
REQ-014 Port ram_addr  out  ADDRESS_WIDTH  bullet RAM slot address.
REQ-015 Port ram_readEn  out  1  bullet RAM read enable.
REQ-016 Port ram_wEn  out  1  bullet RAM write enable.
REQ-017 Port ram_dataIn  out  DATA_WIDTH  bullet RAM write data.
REQ-018 Port ram_dataOut  in  DATA_WIDTH  bullet RAM read data; valid one cycle after ram_readEn.
REQ-019 Port busy  out  1  high while a sweep is in progress.
REQ-020 Port sweep_done  out  1  one-cycle pulse after the last slot has been processed.
REQ-021 Port active_count  out  ADDRESS_WIDTH+1  number of live bullets written in the last sweep.
REQ-022 Port overrun  out  1  sticky flag set when frame_tick arrives while busy.

Function
REQ-023 Record format: [31] active, [30:29] dir (0 up, 1 right, 2 down, 3 left), [28:19] x, [18:10] y, [9:0] life.
REQ-024 States: IDLE, READ, UPDATE, DONE.
REQ-025 In IDLE, frame_tick moves the block to READ with slot index 0 and sets busy.
REQ-026 In READ: ram_readEn=1, ram_wEn=0, ram_addr=index; next state is UPDATE.
REQ-027 In UPDATE: ram_dataOut holds the slot record; ram_wEn=1, ram_readEn=0, ram_addr=index, ram_dataIn=new record.
REQ-028 From UPDATE: next state is READ with index+1, or DONE if index==NUM_BULLETS-1.
REQ-029 DONE lasts one cycle: sweep_done=1, active_count is loaded, busy=0 on the following cycle, and the block returns to IDLE.
REQ-030 A sweep takes exactly 2*NUM_BULLETS+1 cycles from the cycle after frame_tick to the DONE cycle inclusive.
REQ-031 ram_readEn and ram_wEn are never high in the same cycle.
REQ-032 Active record with life==0: written back as all zeros.
REQ-033 Active record with life>0: life decremented by 1 and position moved SPEED pixels in dir.
REQ-034 Position arithmetic uses 11 bits; left/up moves where x<SPEED or y<SPEED deactivate the bullet (record written as zero).
REQ-035 Right/down moves giving x>X_MAX or y>Y_MAX deactivate the bullet (record written as zero).
REQ-036 Inactive slot with the holding register full: spawn_data is written with bit 31 forced to 1 and no movement applied; the holding register is emptied.
REQ-037 Only the first inactive slot in a sweep consumes the held spawn.
REQ-038 Inactive slot with no spawn held: written back unchanged.
REQ-039 Spawn handshake: the holding register loads when spawn_valid && spawn_ready; spawn_ready = !held.
REQ-040 A spawn consumed in the same cycle a new spawn is offered: the new spawn is not accepted until the next cycle.
REQ-041 A held spawn that finds no free slot stays held for the next sweep.
REQ-042 The internal live counter counts every record written with bit 31 set during a sweep; active_count updates only in DONE.
REQ-043 frame_tick while busy is ignored and sets overrun.

Reset
REQ-044 Reset forces IDLE, index=0, holding register empty, busy=0, sweep_done=0, ram_readEn=0, ram_wEn=0, ram_addr=0, ram_dataIn=0, active_count=0, overrun=0, spawn_ready=1.
REQ-045 Reset mid-sweep aborts the sweep immediately; RAM contents are untouched and the next frame_tick restarts at slot 0.

Verification
REQ-046 Slot 5={1,right,x=100,y=50,life=10}, frame_tick -> slot 5 becomes x=102, y=50, life=9; sweep_done 129 cycles after tick; active_count=1.
REQ-047 Slot 0={1,left,x=1,...} -> slot 0 written 0; slot 1={1,down,y=478} -> slot 1 written 0; active_count=0.
REQ-048 Slots 0-2 active, slot 3 inactive, spawn held -> slot 3 = spawn with bit31=1, spawn_ready returns to 1; slot 4 is unchanged.
REQ-049 All 64 slots active, spawn held -> spawn remains held, spawn_ready=0 after the sweep, active_count=64.
REQ-050 frame_tick at sweep cycle 40 -> overrun=1 and timing is unchanged; reset at cycle 60 -> busy=0 next cycle, no further RAM writes.
